// File: rtl/ppg_cal_pkg.sv
// Shared widths, default tuning constants, FSM state type and window helper
// for the PPG auto-calibration controller.
package ppg_cal_pkg;

  localparam int VPPG_W = 8;
  localparam int DC_W   = 7;
  localparam int PGA_W  = 4;
  localparam int BIT_W  = 3;
  localparam int CNT_W  = 16;

  localparam int DEF_WIN_SAMPLES    = 16;
  localparam int DEF_SETTLE_SAMPLES = 2;
  localparam int DEF_MID_TARGET     = 128;
  localparam int DEF_CLIP_HI        = 240;
  localparam int DEF_CLIP_LO        = 15;

  localparam logic [DC_W-1:0]  DC_START  = 7'h40;
  localparam logic [BIT_W-1:0] BIT_START = 3'd6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DC_SAR    = 2'd1,
    GAIN_RAMP = 2'd2,
    DONE      = 2'd3
  } cal_state_e;

  // Window midpoint; the sum needs one extra bit so 255+255 does not wrap.
  function automatic logic [VPPG_W:0] window_mid(input logic [VPPG_W-1:0] mn,
                                                 input logic [VPPG_W-1:0] mx);
    logic [VPPG_W:0] sum;
    sum = {1'b0, mx} + {1'b0, mn};
    return sum >> 1;
  endfunction

endpackage

// File: rtl/ppg_window_stats.sv
// Measurement window: discards settle strobes after each restart, then tracks
// min/max over a fixed number of strobes and pulses win_done_o once.
module ppg_window_stats
  import ppg_cal_pkg::*;
#(
  parameter int WIN_SAMPLES    = DEF_WIN_SAMPLES,
  parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              win_restart_i,
  input  logic              sample_en_i,
  input  logic [VPPG_W-1:0] vppg_i,
  output logic              win_done_o,
  output logic [VPPG_W-1:0] win_min_o,
  output logic [VPPG_W-1:0] win_max_o
);

  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_SAMPLES);
  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_SAMPLES - 1);

  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [VPPG_W-1:0] min_q, min_d;
  logic [VPPG_W-1:0] max_q, max_d;
  logic              done_q, done_d;
  logic              take;

  // Strobes arriving while the finished window waits for its restart are dropped.
  assign take = sample_en_i && !done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      count_q  <= '0;
      min_q    <= '1;
      max_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      settle_q <= settle_d;
      count_q  <= count_d;
      min_q    <= min_d;
      max_q    <= max_d;
      done_q   <= done_d;
    end
  end

  // min starts at all-ones and max at zero so the first kept sample sets both.
  always_comb begin
    settle_d = settle_q;
    count_d  = count_q;
    min_d    = min_q;
    max_d    = max_q;
    done_d   = 1'b0;
    if (win_restart_i) begin
      settle_d = '0;
      count_d  = '0;
      min_d    = '1;
      max_d    = '0;
    end else if (take) begin
      if (settle_q < SETTLE_LIM) begin
        settle_d = settle_q + 1'b1;
      end else begin
        if (vppg_i < min_q) min_d = vppg_i;
        if (vppg_i > max_q) max_d = vppg_i;
        if (count_q == WIN_LAST) begin
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  assign win_done_o = done_q;
  assign win_min_o  = min_q;
  assign win_max_o  = max_q;

endmodule

// File: rtl/ppg_autocal.sv
// PPG front-end auto-calibration: successive approximation of the DC code,
// then a PGA gain ramp that backs off one step once the envelope clips.
module ppg_autocal
  import ppg_cal_pkg::*;
#(
  parameter int WIN_SAMPLES    = DEF_WIN_SAMPLES,
  parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
  parameter int MID_TARGET     = DEF_MID_TARGET,
  parameter int CLIP_HI        = DEF_CLIP_HI,
  parameter int CLIP_LO        = DEF_CLIP_LO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [VPPG_W-1:0] vppg,
  output logic [DC_W-1:0]   dc_comp,
  output logic [PGA_W-1:0]  pga_gain,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              error
);

  localparam logic [VPPG_W:0]   MID_V     = (VPPG_W+1)'(MID_TARGET);
  localparam logic [VPPG_W-1:0] CLIP_HI_V = VPPG_W'(CLIP_HI);
  localparam logic [VPPG_W-1:0] CLIP_LO_V = VPPG_W'(CLIP_LO);

  cal_state_e       state_q, state_d;
  logic [DC_W-1:0]  dc_q, dc_d;
  logic [PGA_W-1:0] gain_q, gain_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic             done_q, done_d;

  logic              start_ok;
  logic              win_restart;
  logic              sample_en;
  logic              win_done;
  logic [VPPG_W-1:0] win_min;
  logic [VPPG_W-1:0] win_max;
  logic [VPPG_W:0]   win_mid;
  logic              win_clip;

  ppg_window_stats #(
    .WIN_SAMPLES    (WIN_SAMPLES),
    .SETTLE_SAMPLES (SETTLE_SAMPLES)
  ) u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .win_restart_i (win_restart),
    .sample_en_i   (sample_en),
    .vppg_i        (vppg),
    .win_done_o    (win_done),
    .win_min_o     (win_min),
    .win_max_o     (win_max)
  );

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign win_mid  = window_mid(win_min, win_max);
  assign win_clip = (win_max > CLIP_HI_V) || (win_min < CLIP_LO_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dc_q     <= '0;
      gain_q   <= '0;
      bit_q    <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dc_q     <= dc_d;
      gain_q   <= gain_d;
      bit_q    <= bit_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  // The front end inverts: raising dc_comp lowers the signal, so a low
  // midpoint means the trial bit overshot and must be cleared.
  always_comb begin
    state_d  = state_q;
    dc_d     = dc_q;
    gain_d   = gain_q;
    bit_d    = bit_q;
    locked_d = locked_q;
    error_d  = error_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DC_SAR;
          dc_d     = DC_START;
          gain_d   = '0;
          bit_d    = BIT_START;
          locked_d = 1'b0;
          error_d  = 1'b0;
        end
      end
      DC_SAR: begin
        if (win_done) begin
          if (win_mid < MID_V) dc_d[bit_q] = 1'b0;
          if (bit_q != '0) begin
            dc_d[bit_q - 3'd1] = 1'b1;
            bit_d              = bit_q - 3'd1;
          end else begin
            state_d = GAIN_RAMP;
            gain_d  = '0;
          end
        end
      end
      GAIN_RAMP: begin
        if (win_done) begin
          if (win_clip) begin
            state_d = DONE;
            done_d  = 1'b1;
            if (gain_q == '0) begin
              error_d  = 1'b1;
              locked_d = 1'b0;
            end else begin
              gain_d   = gain_q - 1'b1;
              locked_d = 1'b1;
            end
          end else if (gain_q == '1) begin
            state_d  = DONE;
            done_d   = 1'b1;
            locked_d = 1'b1;
          end else begin
            gain_d = gain_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every decision also restarts the window so settle discard follows each change.
  always_comb begin
    busy        = 1'b0;
    sample_en   = 1'b0;
    win_restart = start_ok || win_done;
    if (state_q == DC_SAR || state_q == GAIN_RAMP) begin
      busy      = 1'b1;
      sample_en = sample_valid;
    end
  end

  assign dc_comp  = dc_q;
  assign pga_gain = gain_q;
  assign done     = done_q;
  assign locked   = locked_q;
  assign error    = error_q;

endmodule

// File: doc/ppg_autocal.md
# ppg_autocal

Closed-loop calibration controller for the PPG front end, sitting directly upstream of the finger-clip/PGA stage. It consumes the digitised PPG sample `vppg` and drives `dc_comp` and `pga_gain`. On `start` it first finds the DC compensation code by successive approximation. It then ramps the PGA gain until the signal envelope nears the clipping rails, and leaves both settings held for the acquisition path.

## Interface
- `WIN_SAMPLES`, 16: samples evaluated per measurement window (≥2).
- `SETTLE_SAMPLES`, 2: samples discarded after every setting change (≥0).
- `MID_TARGET`, 128: target midpoint for the DC search.
- `CLIP_HI`, 240: window max above this counts as clipping.
- `CLIP_LO`, 15: window min below this counts as clipping.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle calibration request.
- `sample_valid`  in  1  single-cycle strobe; `vppg` is valid in this cycle.
- `vppg`  in  8  unsigned PPG sample.
- `dc_comp`  out  7  DC compensation code to the front end.
- `pga_gain`  out  4  PGA gain code to the front end.
- `busy`  out  1  calibration in progress.
- `done`  out  1  one-cycle pulse when calibration ends, for either success or error.
- `locked`  out  1  level; last calibration succeeded.
- `error`  out  1  level; last calibration failed.

## Operation
- States:
  - IDLE: entered from reset.
  - DC_SAR: successive approximation on `dc_comp`.
  - GAIN_RAMP: step `pga_gain` upward.
  - DONE.
- `start` is accepted in IDLE or DONE and ignored while `busy`. On acceptance:
  - `dc_comp`=7'h40, `pga_gain`=0.
  - `locked`=0, `error`=0, `busy`=1.
  - Bit index = 6.
- Measurement window:
  - Counts `sample_valid` strobes only.
  - Discards the first SETTLE_SAMPLES strobes.
  - Over the next WIN_SAMPLES strobes it tracks min and max of `vppg`.
  - At window end: mid = (max+min)>>1, computed in 9 bits.
- DC_SAR, one window per bit, bit 6 down to 0:
  - If mid < MID_TARGET, clear the trial bit; otherwise keep it.
  - If bit > 0, set the next lower bit and start a new window.
  - After bit 0 is decided, go to GAIN_RAMP with `pga_gain`=0.
  - Note: the front end output falls as `dc_comp` rises. The result is therefore the largest code with mid ≥ MID_TARGET.
- GAIN_RAMP, one window per gain code. A window clips if max > CLIP_HI or min < CLIP_LO.
  - Clips at `pga_gain`=0: `error`=1, `locked`=0, `pga_gain` stays 0 → DONE.
  - Clips at `pga_gain`>0: `pga_gain`−1, `locked`=1 → DONE.
  - No clip at `pga_gain`=15: `locked`=1 → DONE.
  - No clip otherwise: `pga_gain`+1, new window.
- DONE: `busy`=0, `done` pulses once. `dc_comp` and `pga_gain` are held until the next accepted `start`.
- `start` and `sample_valid` in the same cycle: start wins and that sample is not counted.
- Reset mid-operation: all state and outputs return to reset values immediately. Any partial window is discarded.

## Timing
- Reset values: `dc_comp`=0, `pga_gain`=0, `busy`=0, `done`=0, `locked`=0, `error`=0, state IDLE.
- `start` sampled at edge N: `busy` and the new outputs are visible after edge N.
- The last window sample is captured at edge M. The decision is registered at edge M+1: new `dc_comp`/`pga_gain` values and the state change, including `done`=1 on entry to DONE.
- `done` is high for exactly one cycle. `busy` falls in the same cycle `done` rises.
- `sample_valid` strobes received during the decision cycle, or while not `busy`, are ignored.
- Worst case run length: 7 + 16 windows × (SETTLE_SAMPLES+WIN_SAMPLES) strobes.
- No combinational path from inputs to outputs.

## Structure
- Package `ppg_cal_pkg`:
  - state enum (IDLE, DC_SAR, GAIN_RAMP, DONE);
  - widths: VPPG_W=8, DC_W=7, PGA_W=4;
  - default parameter constants.
- Sub-module `ppg_window_stats`:
  - settle discard, sample counter, min/max registers;
  - outputs a one-cycle `win_done` pulse with `win_min`/`win_max`;
  - cleared by a `win_restart` pulse from the controller FSM.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → all outputs 0, state IDLE; `start` while in reset has no effect.
- Nominal: a bench model alternates per strobe between (255−2·dc)+16·pga and (255−2·dc)−16·pga, each saturated to 0..255. Pulse `start` → `dc_comp`=63, `pga_gain`=6, `locked`=1, `error`=0, `done` after exactly 270 strobes plus 1 cycle.
- Stuck-high input, `vppg`=255 constant → `dc_comp`=127, `pga_gain`=0, `error`=1, `locked`=0, one `done` pulse.
- Stuck-low input, `vppg`=0 constant → `dc_comp`=0, `pga_gain`=0, `error`=1.
- Reset after 100 strobes of the nominal run → outputs return to reset values immediately. A subsequent `start` completes identically to the nominal scenario.
- `start` while `busy` → ignored, run unchanged. `start` coincident with `sample_valid` → that sample is not counted, and the run still takes 270 further strobes.
